// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game datapath blocks.
//   dir_t          : tank / bullet facing (UP, RIGHT, DOWN, LEFT)
//   bullet_state_t : bullet controller FSM encoding
//   HIT_BULLET     : collision verdict meaning "bullet struck wall or tank"
//   X_MAX / Y_MAX  : last visible column / row
//   widen()        : zero-extend a 10-bit coordinate to 11 bits for
//                    overflow-free boundary arithmetic
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_t;

  localparam logic [1:0] HIT_BULLET = 2'b10;
  localparam logic [9:0] X_MAX      = 10'd639;
  localparam logic [9:0] Y_MAX      = 10'd479;

  function automatic logic [10:0] widen(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: turns the vsync-rate frame_clk level into a single
// clk-cycle pulse on its rising edge. frame_clk is treated as an ordinary
// synchronous input; the two history flops are the only sampling stage.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   frame_clk in  frame strobe level
//   tick      out one-cycle pulse after a 0->1 transition of frame_clk
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic tick
);

  logic [1:0] hist;  // hist[0] newest sample, hist[1] previous one

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], frame_clk};
    end
  end

  assign tick = hist[0] & ~hist[1];

endmodule

// File: rtl/bullet_controller.sv
// Per-tank bullet controller. Launches a bullet from the tank muzzle on fire,
// advances it one STEP per frame tick, and retires it on a collision verdict,
// on reaching the screen edge, or when its lifetime runs out; a cooldown then
// blocks re-fire. fire must be released between shots (armed).
//
// Handshake/status: "ready" is high while IDLE with fire re-armed; a launch
// happens on the tick where ready && fire && the spawn fits on screen.
// "active" qualifies X_Bullet/Y_Bullet for the collision stage.
//
//   Clk, Reset_n            clock, async active-low reset
//   frame_clk               frame strobe (rising edge = tick)
//   fire                    fire button level
//   dir                     tank facing (0 up, 1 right, 2 down, 3 left)
//   X_Tank, Y_Tank          tank top-left corner
//   Tank_Width, Tank_Height tank size
//   hit                     collision verdict (2'b10 = bullet hit)
//   X_Bullet, Y_Bullet      bullet top-left corner
//   active                  bullet in flight
//   ready                   IDLE and re-armed
//   state                   current FSM state (bullet_state_t encoding)
module bullet_controller
  import tank_pkg::*;
#(
  parameter logic [9:0] STEP        = 10'd4,
  parameter logic [9:0] BULLET_SIZE = 10'd4,
  parameter logic [7:0] LIFETIME    = 8'd120,
  parameter logic [7:0] COOLDOWN_T  = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [1:0] dir,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [9:0] Tank_Width,
  input  logic [9:0] Tank_Height,
  input  logic [1:0] hit,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic       active,
  output logic       ready,
  output logic [1:0] state
);

  logic          tick;
  bullet_state_t state_q;
  dir_t          dir_q;
  dir_t          dir_in;
  logic [7:0]    life_cnt;
  logic [7:0]    cd_cnt;
  logic          armed;

  logic [9:0]    cx, cy, spawn_x, spawn_y, next_x, next_y;
  logic          spawn_ok, step_out;

  frame_tick_gen u_tick (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  assign dir_in = dir_t'(dir);

  // Muzzle position and legality of the launch for the current facing.
  always_comb begin
    cx       = X_Tank + (Tank_Width >> 1) - (BULLET_SIZE >> 1);
    cy       = Y_Tank + (Tank_Height >> 1) - (BULLET_SIZE >> 1);
    spawn_x  = cx;
    spawn_y  = cy;
    spawn_ok = 1'b0;
    case (dir_in)
      UP: begin
        spawn_y  = Y_Tank - BULLET_SIZE;
        spawn_ok = (Y_Tank >= BULLET_SIZE);
      end
      DOWN: begin
        spawn_y  = Y_Tank + Tank_Height;
        spawn_ok = (widen(Y_Tank) + widen(Tank_Height) + widen(BULLET_SIZE))
                   <= (widen(Y_MAX) + 11'd1);
      end
      LEFT: begin
        spawn_x  = X_Tank - BULLET_SIZE;
        spawn_ok = (X_Tank >= BULLET_SIZE);
      end
      RIGHT: begin
        spawn_x  = X_Tank + Tank_Width;
        spawn_ok = (widen(X_Tank) + widen(Tank_Width) + widen(BULLET_SIZE))
                   <= (widen(X_MAX) + 11'd1);
      end
    endcase
  end

  // Would the next step put any part of the bullet off screen? Bullets never
  // wrap: they retire instead.
  always_comb begin
    next_x   = X_Bullet;
    next_y   = Y_Bullet;
    step_out = 1'b0;
    case (dir_q)
      UP: begin
        next_y   = Y_Bullet - STEP;
        step_out = (Y_Bullet < STEP);
      end
      DOWN: begin
        next_y   = Y_Bullet + STEP;
        step_out = (widen(Y_Bullet) + widen(STEP) + widen(BULLET_SIZE))
                   > (widen(Y_MAX) + 11'd1);
      end
      LEFT: begin
        next_x   = X_Bullet - STEP;
        step_out = (X_Bullet < STEP);
      end
      RIGHT: begin
        next_x   = X_Bullet + STEP;
        step_out = (widen(X_Bullet) + widen(STEP) + widen(BULLET_SIZE))
                   > (widen(X_MAX) + 11'd1);
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      dir_q    <= UP;
      life_cnt <= 8'd0;
      cd_cnt   <= 8'd0;
      armed    <= 1'b0;
      active   <= 1'b0;
      X_Bullet <= 10'd0;
      Y_Bullet <= 10'd0;
    end else begin
      // Re-arm is the only state change allowed off-tick.
      if (!fire) armed <= 1'b1;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (armed && fire && spawn_ok) begin
              state_q  <= FLYING;
              dir_q    <= dir_in;
              life_cnt <= LIFETIME - 8'd1;
              active   <= 1'b1;
              X_Bullet <= spawn_x;
              Y_Bullet <= spawn_y;
              armed    <= 1'b0;
            end
          end
          FLYING: begin
            // Priority: hit, then screen edge, then lifetime; position holds.
            if ((hit == HIT_BULLET) || step_out || (life_cnt == 8'd0)) begin
              state_q <= COOLDOWN;
              active  <= 1'b0;
              cd_cnt  <= COOLDOWN_T - 8'd1;
            end else begin
              X_Bullet <= next_x;
              Y_Bullet <= next_y;
              life_cnt <= life_cnt - 8'd1;
            end
          end
          COOLDOWN: begin
            if (cd_cnt == 8'd0) state_q <= IDLE;
            else                cd_cnt  <= cd_cnt - 8'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ready = (state_q == IDLE) && armed;
  assign state = state_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller. Each frame tick issued by the driver pushes the
// expected {active, ready, state, X, Y} observed one cycle after the tick; a
// monitor pops and compares whenever the outputs update after a tick.
module tb_bullet_controller;

  localparam int W = 24;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FLY  = 2'd1;
  localparam logic [1:0] S_CD   = 2'd2;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [9:0] X_Tank = 10'd0, Y_Tank = 10'd0;
  logic [9:0] Tank_Width = 10'd32, Tank_Height = 10'd32;
  logic [1:0] hit = 2'b00;
  logic [9:0] X_Bullet, Y_Bullet;
  logic       active, ready;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_vec = 0;
  int           n_fail = 0;
  logic [1:0]   mon_h = 2'b00;
  logic         upd = 1'b0;

  bullet_controller dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
    .dir(dir), .X_Tank(X_Tank), .Y_Tank(Y_Tank), .Tank_Width(Tank_Width),
    .Tank_Height(Tank_Height), .hit(hit), .X_Bullet(X_Bullet),
    .Y_Bullet(Y_Bullet), .active(active), .ready(ready), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got timeout required completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] pack(input logic a, r, input logic [1:0] st,
                                        input logic [9:0] x, y);
    return {a, r, st, x, y};
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got act=%0b rdy=%0b st=%0d x=%0d y=%0d, required act=%0b rdy=%0b st=%0d x=%0d y=%0d",
               name, got[23], got[22], got[21:20], got[19:10], got[9:0],
               exp[23], exp[22], exp[21:20], exp[19:10], exp[9:0]);
    end
  endtask

  // Independent model of the tick timing: outputs update on the edge after
  // the cycle in which frame_clk's rise was first sampled.
  always @(posedge Clk) begin
    upd   <= mon_h[0] & ~mon_h[1];
    mon_h <= {mon_h[0], frame_clk};
  end

  always @(negedge Clk) begin
    if (upd && Reset_n) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_update: got output update, required none");
      end else begin
        check(tag_q.pop_front(), pack(active, ready, state, X_Bullet, Y_Bullet),
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; issues one frame tick and returns at a negedge.
  task automatic tick_exp(input string tag, input logic a, r,
                          input logic [1:0] st, input logic [9:0] x, y);
    exp_q.push_back(pack(a, r, st, x, y));
    tag_q.push_back(tag);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_tank(input logic [9:0] x, y, w, h, input logic [1:0] d);
    X_Tank = x; Y_Tank = y; Tank_Width = w; Tank_Height = h; dir = d;
  endtask

  // 29 decrementing ticks, then the tick that returns to IDLE (fire released).
  task automatic run_cooldown(input logic [9:0] x, y);
    for (int i = 1; i < 30; i++) tick_exp("cooldown", 1'b0, 1'b0, S_CD, x, y);
    tick_exp("cooldown_end", 1'b0, 1'b1, S_IDLE, x, y);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("reset_values", pack(active, ready, state, X_Bullet, Y_Bullet), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Launch right: tank (100,200) 32x32
    set_tank(10'd100, 10'd200, 10'd32, 10'd32, 2'd1);
    fire = 1'b1;
    tick_exp("launch_right", 1'b1, 1'b0, S_FLY, 10'd132, 10'd214);
    for (int i = 1; i <= 3; i++)
      tick_exp("fly_right", 1'b1, 1'b0, S_FLY, 10'(132 + 4 * i), 10'd214);
    hit = 2'b11;
    tick_exp("hit_code_ignored", 1'b1, 1'b0, S_FLY, 10'd148, 10'd214);
    hit = 2'b10;
    tick_exp("wall_hit", 1'b0, 1'b0, S_CD, 10'd148, 10'd214);
    hit = 2'b00;

    // Cooldown: fire held, released, pressed again; exactly 30 ticks to IDLE.
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) fire = 1'b0;
      if (i == 21) fire = 1'b1;
      if (i < 30) tick_exp("cooldown_fire", 1'b0, 1'b0, S_CD, 10'd148, 10'd214);
      else        tick_exp("cooldown_done", 1'b0, 1'b1, S_IDLE, 10'd148, 10'd214);
    end
    tick_exp("refire", 1'b1, 1'b0, S_FLY, 10'd132, 10'd214);
    fire = 1'b0;
    dir = 2'd0;
    tick_exp("dir_change_ignored", 1'b1, 1'b0, S_FLY, 10'd136, 10'd214);
    hit = 2'b10;
    tick_exp("wall_hit2", 1'b0, 1'b0, S_CD, 10'd136, 10'd214);
    hit = 2'b00;
    run_cooldown(10'd136, 10'd214);

    // Top edge: no wrap
    set_tank(10'd100, 10'd10, 10'd32, 10'd32, 2'd0);
    fire = 1'b1;
    tick_exp("launch_up", 1'b1, 1'b0, S_FLY, 10'd114, 10'd6);
    fire = 1'b0;
    tick_exp("fly_up", 1'b1, 1'b0, S_FLY, 10'd114, 10'd2);
    tick_exp("top_edge", 1'b0, 1'b0, S_CD, 10'd114, 10'd2);
    run_cooldown(10'd114, 10'd2);

    // Illegal spawns in all four directions; ready stays high.
    fire = 1'b1;
    set_tank(10'd100, 10'd2, 10'd32, 10'd32, 2'd0);
    tick_exp("illegal_up", 1'b0, 1'b1, S_IDLE, 10'd114, 10'd2);
    set_tank(10'd3, 10'd100, 10'd32, 10'd32, 2'd3);
    tick_exp("illegal_left", 1'b0, 1'b1, S_IDLE, 10'd114, 10'd2);
    set_tank(10'd621, 10'd100, 10'd16, 10'd16, 2'd1);
    tick_exp("illegal_right", 1'b0, 1'b1, S_IDLE, 10'd114, 10'd2);
    set_tank(10'd100, 10'd464, 10'd16, 10'd16, 2'd2);
    tick_exp("illegal_down", 1'b0, 1'b1, S_IDLE, 10'd114, 10'd2);

    // Right-edge spawn exactly at the limit, then retire at the edge.
    set_tank(10'd620, 10'd100, 10'd16, 10'd16, 2'd1);
    tick_exp("edge_spawn_right", 1'b1, 1'b0, S_FLY, 10'd636, 10'd106);
    fire = 1'b0;
    tick_exp("right_edge", 1'b0, 1'b0, S_CD, 10'd636, 10'd106);
    run_cooldown(10'd636, 10'd106);

    // Lifetime: 119 moves, retire on the 120th tick in flight.
    set_tank(10'd0, 10'd0, 10'd16, 10'd16, 2'd1);
    fire = 1'b1;
    tick_exp("launch_life", 1'b1, 1'b0, S_FLY, 10'd16, 10'd6);
    fire = 1'b0;
    for (int i = 1; i <= 119; i++)
      tick_exp("life_fly", 1'b1, 1'b0, S_FLY, 10'(16 + 4 * i), 10'd6);
    tick_exp("life_expire", 1'b0, 1'b0, S_CD, 10'd492, 10'd6);
    run_cooldown(10'd492, 10'd6);

    // Launch down, then reset mid-flight.
    set_tank(10'd300, 10'd200, 10'd32, 10'd32, 2'd2);
    fire = 1'b1;
    tick_exp("launch_down", 1'b1, 1'b0, S_FLY, 10'd314, 10'd232);
    fire = 1'b0;
    tick_exp("fly_down", 1'b1, 1'b0, S_FLY, 10'd314, 10'd236);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("reset_mid_flight", pack(active, ready, state, X_Bullet, Y_Bullet), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    tick_exp("post_reset", 1'b0, 1'b1, S_IDLE, 10'd0, 10'd0);

    repeat (4) @(negedge Clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
